// File: rtl/ara_resp_join.sv
// Joins per-cluster accelerator responses into one merged response towards CVA6.
// Each cluster's responses are buffered in a small FIFO and released together once all clusters have answered.
module ara_resp_join #(
    parameter int NrClusters   = 4,
    parameter int ResultWidth  = 64,
    parameter int TransIdWidth = 3,
    parameter int Depth        = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrClusters-1:0]              resp_valid_i,
    output logic [NrClusters-1:0]              resp_ready_o,
    input  logic [NrClusters*ResultWidth-1:0]  resp_result_i,
    input  logic [NrClusters*TransIdWidth-1:0] resp_id_i,
    input  logic [NrClusters-1:0]              resp_exc_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [ResultWidth-1:0]             out_result_o,
    output logic [TransIdWidth-1:0]            out_id_o,
    output logic                               out_exc_o,
    output logic                               id_error_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [NrClusters-1:0]   full;
    logic [NrClusters-1:0]   empty;
    logic [NrClusters-1:0]   push;
    logic [NrClusters-1:0]   head_exc;
    logic [ResultWidth-1:0]  head_res [NrClusters];
    logic [TransIdWidth-1:0] head_id  [NrClusters];
    logic                    pop;
    logic                    exc_any;
    logic                    id_mismatch;
    logic                    id_error;

    assign out_valid_o = &(~empty);
    assign pop         = out_valid_o && out_ready_i;

    for (genvar g = 0; g < NrClusters; g++) begin : g_fifo
        logic [ResultWidth-1:0]  res_mem [Depth];
        logic [TransIdWidth-1:0] id_mem  [Depth];
        logic                    exc_mem [Depth];
        logic [PtrW-1:0]         wptr;
        logic [PtrW-1:0]         rptr;
        logic [CntW-1:0]         cnt;

        // Ready is purely a function of the registered count, so a full FIFO refuses even when a pop happens.
        assign full[g]         = (cnt == CntFull);
        assign empty[g]        = (cnt == '0);
        assign push[g]         = resp_valid_i[g] && !full[g];
        assign resp_ready_o[g] = !full[g];
        assign head_res[g]     = res_mem[rptr];
        assign head_id[g]      = id_mem[rptr];
        assign head_exc[g]     = exc_mem[rptr];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push[g]) wptr <= wptr + PtrW'(1);
                if (pop)     rptr <= rptr + PtrW'(1);
                case ({push[g], pop})
                    2'b10:   cnt <= cnt + CntW'(1);
                    2'b01:   cnt <= cnt - CntW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (push[g]) begin
                res_mem[wptr] <= resp_result_i[g*ResultWidth +: ResultWidth];
                id_mem[wptr]  <= resp_id_i[g*TransIdWidth +: TransIdWidth];
                exc_mem[wptr] <= resp_exc_i[g];
            end
        end
    end

    always_comb begin
        exc_any     = |head_exc;
        id_mismatch = 1'b0;
        for (int c = 1; c < NrClusters; c++) begin
            if (head_id[c] != head_id[0]) id_mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_error <= 1'b0;
        end else if (pop && id_mismatch) begin
            id_error <= 1'b1;
        end
    end

    // Storage is not reset; gating with valid keeps the data outputs at zero while nothing is joined.
    assign out_result_o = out_valid_o ? head_res[0] : '0;
    assign out_id_o     = out_valid_o ? head_id[0]  : '0;
    assign out_exc_o    = out_valid_o && exc_any;
    assign id_error_o   = id_error;

endmodule

// File: tb/tb_ara_resp_join.sv
// Bench for ara_resp_join: directed scenarios plus randomized traffic against a queue-based model.
module tb_ara_resp_join;

    localparam int NC    = 4;
    localparam int RW    = 64;
    localparam int IW    = 3;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     resp_valid;
    logic [NC-1:0]     resp_ready;
    logic [NC*RW-1:0]  resp_result;
    logic [NC*IW-1:0]  resp_id;
    logic [NC-1:0]     resp_exc;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_result;
    logic [IW-1:0]     out_id;
    logic              out_exc;
    logic              id_error;

    always #5 clk = ~clk;

    ara_resp_join #(
        .NrClusters(NC), .ResultWidth(RW), .TransIdWidth(IW), .Depth(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .resp_valid_i(resp_valid), .resp_ready_o(resp_ready),
        .resp_result_i(resp_result), .resp_id_i(resp_id), .resp_exc_i(resp_exc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_id_o(out_id), .out_exc_o(out_exc),
        .id_error_o(id_error)
    );

    typedef struct packed {
        logic [RW-1:0] res;
        logic [IW-1:0] id;
        logic          exc;
    } ent_t;

    ent_t mq [NC][$];
    logic m_id_err = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: one queue per cluster, joined when every queue holds an entry.
    always @(posedge clk or negedge rst_n) begin : model
        logic [NC-1:0] rdy;
        logic          all_ne;
        logic          mm;
        ent_t          e;
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_id_err = 1'b0;
        end else begin
            all_ne = 1'b1;
            for (int c = 0; c < NC; c++) begin
                rdy[c] = (mq[c].size() < DEPTH);
                if (mq[c].size() == 0) all_ne = 1'b0;
            end
            if (all_ne && out_ready) begin
                mm = 1'b0;
                for (int c = 0; c < NC; c++)
                    if (mq[c][0].id != mq[0][0].id) mm = 1'b1;
                if (mm) m_id_err = 1'b1;
                for (int c = 0; c < NC; c++) void'(mq[c].pop_front());
            end
            for (int c = 0; c < NC; c++) begin
                if (resp_valid[c] && rdy[c]) begin
                    e.res = resp_result[c*RW +: RW];
                    e.id  = resp_id[c*IW +: IW];
                    e.exc = resp_exc[c];
                    mq[c].push_back(e);
                end
            end
        end
    end

    // Compare process, sampling mid-cycle.
    always @(negedge clk) begin : compare
        logic [NC-1:0] exp_rdy;
        logic          exp_vld;
        logic          exp_exc;
        #1;
        if (!rst_n) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_ready", resp_ready, 4'hF);
            chk("rst_iderr", id_error, 0);
            chk("rst_result", out_result, 0);
        end else begin
            exp_vld = 1'b1;
            exp_exc = 1'b0;
            for (int c = 0; c < NC; c++) begin
                exp_rdy[c] = (mq[c].size() < DEPTH);
                if (mq[c].size() == 0) exp_vld = 1'b0;
            end
            chk("ready", resp_ready, exp_rdy);
            chk("valid", out_valid, exp_vld);
            chk("id_error", id_error, m_id_err);
            if (exp_vld) begin
                for (int c = 0; c < NC; c++) exp_exc = exp_exc | mq[c][0].exc;
                chk("result", out_result, mq[0][0].res);
                chk("id", out_id, mq[0][0].id);
                chk("exc", out_exc, exp_exc);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, return just after the next rising edge.
    task automatic cyc(input logic [NC-1:0] v, input logic [NC*IW-1:0] ids, input logic [NC-1:0] ex,
                       input logic [RW-1:0] rbase, input logic ordy);
        @(negedge clk);
        resp_valid = v;
        resp_id    = ids;
        resp_exc   = ex;
        for (int c = 0; c < NC; c++) resp_result[c*RW +: RW] = rbase + RW'(c);
        out_ready  = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NC*IW-1:0] ids;
        logic [IW-1:0]    base;
        logic [NC-1:0]    v;
        resp_valid  = '0;
        resp_result = '0;
        resp_id     = '0;
        resp_exc    = '0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_valid", out_valid, 0);
        chk("t1_ready", resp_ready, 4'hF);
        chk("t1_iderr", id_error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arrival in cycles 1,3,2,6 for clusters 0..3
        cyc(4'b0001, {4{3'd5}}, '0, 64'hCAFE, 1'b1);
        cyc(4'b0100, {4{3'd5}}, '0, 64'hCAFE, 1'b1);
        cyc(4'b0010, {4{3'd5}}, '0, 64'hCAFE, 1'b1);
        cyc(4'b0000, {4{3'd5}}, '0, 64'hCAFE, 1'b1);
        cyc(4'b0000, {4{3'd5}}, '0, 64'hCAFE, 1'b1);
        chk("t2_not_yet", out_valid, 0);
        cyc(4'b1000, {4{3'd5}}, '0, 64'hCAFE, 1'b1);
        chk("t2_valid", out_valid, 1);
        chk("t2_result", out_result, 64'hCAFE);
        chk("t2_id", out_id, 5);
        cyc(4'b0000, {4{3'd5}}, '0, 64'h0, 1'b1);
        chk("t2_popped", out_valid, 0);

        // Backpressure fills every FIFO, then drains
        cyc(4'hF, {4{3'd1}}, '0, 64'h100, 1'b0);
        chk("t3_ready1", resp_ready, 4'hF);
        cyc(4'hF, {4{3'd2}}, '0, 64'h200, 1'b0);
        chk("t3_full", resp_ready, 4'h0);
        chk("t3_result1", out_result, 64'h100);
        cyc(4'hF, {4{3'd3}}, '0, 64'h300, 1'b0);
        chk("t3_stable_res", out_result, 64'h100);
        chk("t3_stable_id", out_id, 1);
        cyc(4'hF, {4{3'd3}}, '0, 64'h300, 1'b1);
        chk("t3_join1", out_result, 64'h200);
        chk("t3_ready2", resp_ready, 4'hF);
        cyc(4'hF, {4{3'd3}}, '0, 64'h300, 1'b1);
        chk("t3_join2", out_result, 64'h300);
        cyc(4'h0, {4{3'd3}}, '0, 64'h0, 1'b1);
        chk("t3_drained", out_valid, 0);

        // Exception from one cluster
        cyc(4'hF, {4{3'd5}}, 4'b0100, 64'h400, 1'b0);
        chk("t4_exc1", out_exc, 1);
        cyc(4'hF, {4{3'd5}}, 4'b0000, 64'h500, 1'b1);
        chk("t4_exc0", out_exc, 0);
        chk("t4_result", out_result, 64'h500);
        cyc(4'h0, {4{3'd5}}, '0, 64'h0, 1'b1);

        // ID mismatch on cluster 3
        cyc(4'hF, {3'd4, 3'd5, 3'd5, 3'd5}, '0, 64'h600, 1'b1);
        chk("t5_id", out_id, 5);
        chk("t5_err_before", id_error, 0);
        cyc(4'h0, {4{3'd5}}, '0, 64'h0, 1'b1);
        chk("t5_err_set", id_error, 1);
        repeat (3) cyc(4'h0, {4{3'd5}}, '0, 64'h0, 1'b1);
        chk("t5_err_sticky", id_error, 1);

        // Reset with partial contents
        cyc(4'b0011, {4{3'd5}}, '0, 64'h700, 1'b0);
        chk("t6_partial_valid", out_valid, 0);
        @(negedge clk);
        rst_n      = 1'b0;
        resp_valid = '0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_iderr", id_error, 0);
        chk("t6_rst_ready", resp_ready, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'hF, {4{3'd6}}, '0, 64'hBEEF, 1'b0);
        chk("t6_fresh_valid", out_valid, 1);
        chk("t6_fresh_result", out_result, 64'hBEEF);
        chk("t6_fresh_id", out_id, 6);
        cyc(4'h0, {4{3'd6}}, '0, 64'h0, 1'b1);
        chk("t6_fresh_pop", out_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                rst_n      = 1'b0;
                resp_valid = '0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                base = IW'($urandom);
                for (int c = 0; c < NC; c++)
                    ids[c*IW +: IW] = ($urandom_range(0, 15) == 0) ? IW'($urandom) : base;
                for (int c = 0; c < NC; c++) v[c] = ($urandom_range(0, 9) < 7);
                cyc(v, ids, NC'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    {$urandom, $urandom}, ($urandom_range(0, 9) < 6));
            end
        end

        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
